win_sprite_renderer: RTL and testbench

Downstream consumer of the win-screen sprite ROM (150×120, 5-bit palette indices, 1-cycle registered read). For each pixel the VGA controller scans, it generates the ROM read address and realigns the returned index with the scan position. It maps the index to 24-bit RGB through a fixed palette and applies a frame-based fade-in. Its RGB/valid outputs feed the top-level colour mux, which overlays the win screen on the game layer.

---
 rtl/win_sprite_renderer_pkg.sv | 16 +
 rtl/win_sprite_renderer_if.sv | 12 +
 rtl/win_sprite_renderer_palette_scale.sv | 25 ++
 rtl/win_sprite_renderer.sv | 112 +++++++++++
 tb/tb_win_sprite_renderer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/win_sprite_renderer_pkg.sv
// Shared types and constants for the win-screen sprite renderer.
package win_render_pkg;

    typedef enum logic [1:0] {IDLE, FADE, SHOW} state_t;

    localparam int unsigned LEVEL_MAX = 7;

    // Index 0 is transparent; its colour is never shown.
    localparam logic [23:0] PALETTE [32] = '{
        24'h000000, 24'hFFFFFF, 24'h202020, 24'hE0C020, 24'h3060C0, 24'hFF8040, 24'h40FF40, 24'hFF4040,
        24'h4040FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h804000, 24'h008040, 24'h400080, 24'hC0C0C0,
        24'h808080, 24'h604020, 24'hF0E0A0, 24'hA0E0F0, 24'hFFD700, 24'hDAA520, 24'hB8860B, 24'h8B4513,
        24'h2E8B57, 24'h4682B4, 24'h6A5ACD, 24'hDC143C, 24'hFF69B4, 24'hF5DEB3, 24'h708090, 24'h101010
    };

endpackage

// File: rtl/win_sprite_renderer_if.sv
// Sprite ROM read bus plus the overlay pixel output towards the colour mux.
interface win_sprite_renderer_if;
    logic [14:0] read_address;
    logic [4:0]  rom_data;
    logic        pixel_valid;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;

    modport master (output read_address, pixel_valid, Red, Green, Blue, input rom_data);
    modport slave  (input read_address, pixel_valid, Red, Green, Blue, output rom_data);
endinterface

// File: rtl/win_sprite_renderer_palette_scale.sv
// Combinational palette lookup with fade brightness: c*(level+1)>>3 per channel.
module win_palette_scale
    import win_render_pkg::*;
(
    input  logic [4:0] index,
    input  logic [2:0] level,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);
    logic [23:0] rgb;
    logic [3:0]  mult;
    logic [10:0] pr, pg, pb;

    always_comb begin
        rgb   = PALETTE[index];
        mult  = {1'b0, level} + 4'd1;
        pr    = {3'b000, rgb[23:16]} * {7'd0, mult};
        pg    = {3'b000, rgb[15:8]}  * {7'd0, mult};
        pb    = {3'b000, rgb[7:0]}   * {7'd0, mult};
        red   = pr[10:3];
        green = pg[10:3];
        blue  = pb[10:3];
    end
endmodule

// File: rtl/win_sprite_renderer.sv
// Win-screen overlay: ROM address generation, 3-stage pixel pipeline and fade-in FSM.
module win_sprite_renderer
    import win_render_pkg::*;
#(
    parameter int unsigned SPR_W     = 150,
    parameter int unsigned SPR_H     = 120,
    parameter int unsigned ORIGIN_X  = 245,
    parameter int unsigned ORIGIN_Y  = 180,
    parameter int unsigned FADE_STEP = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    input  logic                         frame_start,
    input  logic                         win_trigger,
    input  logic                         win_clear,
    output logic                         overlay_active,
    win_sprite_renderer_if.master        bus
);
    localparam int unsigned FCW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [9:0] X_LO = 10'(ORIGIN_X);
    localparam logic [9:0] X_HI = 10'(ORIGIN_X + SPR_W);
    localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
    localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + SPR_H);

    state_t       state;
    logic [2:0]   level;
    logic [FCW-1:0] fcnt;

    logic         in_box, in_box_d1, in_box_d2, opaque;
    logic [6:0]   row;
    logic [7:0]   col;
    logic [14:0]  addr;
    logic [7:0]   sr, sg, sb;

    always_comb begin
        in_box = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
        row    = 7'(DrawY - Y_LO);
        col    = 8'(DrawX - X_LO);
        // Full 15-bit product so the last pixel (17999) is not truncated.
        addr   = ({8'd0, row} * 15'(SPR_W)) + {7'd0, col};
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.read_address <= '0;
            in_box_d1        <= 1'b0;
            in_box_d2        <= 1'b0;
        end else begin
            bus.read_address <= in_box ? addr : '0;
            in_box_d1        <= in_box;
            in_box_d2        <= in_box_d1;
        end
    end

    win_palette_scale u_scale (
        .index (bus.rom_data),
        .level (level),
        .red   (sr),
        .green (sg),
        .blue  (sb)
    );

    assign opaque = in_box_d2 && (bus.rom_data != '0) && (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.pixel_valid <= 1'b0;
            bus.Red         <= '0;
            bus.Green       <= '0;
            bus.Blue        <= '0;
        end else begin
            bus.pixel_valid <= opaque;
            bus.Red         <= opaque ? sr : '0;
            bus.Green       <= opaque ? sg : '0;
            bus.Blue        <= opaque ? sb : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state          <= IDLE;
            level          <= '0;
            fcnt           <= '0;
            overlay_active <= 1'b0;
        end else if (win_clear) begin
            state          <= IDLE;
            overlay_active <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win_trigger) begin
                    state          <= FADE;
                    level          <= '0;
                    fcnt           <= '0;
                    overlay_active <= 1'b1;
                end
                FADE: if (frame_start) begin
                    if (fcnt == FCW'(FADE_STEP - 1)) begin
                        fcnt  <= '0;
                        level <= level + 3'd1;
                        if (level == 3'(LEVEL_MAX - 1)) state <= SHOW;
                    end else begin
                        fcnt <= fcnt + FCW'(1);
                    end
                end
                SHOW: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_win_sprite_renderer.sv
// Directed bench with a registered ROM model and a cycle-tagged scoreboard.
module tb_win_sprite_renderer;
    import win_render_pkg::*;

    typedef struct {
        int unsigned due;
        int          id;
        logic        v;
        logic [23:0] rgb;
    } px_t;

    typedef struct {
        int unsigned due;
        int          id;
        logic [14:0] a;
    } ad_t;

    logic       clk;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic       frame_start, win_trigger, win_clear;
    logic       overlay_active;

    win_sprite_renderer_if bus ();

    win_sprite_renderer #(
        .SPR_W     (150),
        .SPR_H     (120),
        .ORIGIN_X  (245),
        .ORIGIN_Y  (180),
        .FADE_STEP (4)
    ) dut (
        .Clk            (clk),
        .Reset_n        (Reset_n),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .frame_start    (frame_start),
        .win_trigger    (win_trigger),
        .win_clear      (win_clear),
        .overlay_active (overlay_active),
        .bus            (bus)
    );

    int unsigned cyc = 0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    int          next_id = 0;
    px_t         pq[$];
    ad_t         aq[$];

    // Bench-side model state: 0 idle, 1 fade, 2 show
    int m_state = 0;
    int m_lvl = 0;
    int m_fcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] rom_fn(logic [14:0] a);
        return a[4:0] + 5'd3;
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.read_address);

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [23:0] scale_rgb(logic [23:0] c, int lvl);
        int r, g, b;
        r = (int'(c[23:16]) * (lvl + 1)) / 8;
        g = (int'(c[15:8])  * (lvl + 1)) / 8;
        b = (int'(c[7:0])   * (lvl + 1)) / 8;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    always @(negedge clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ad_t e;
            e = aq.pop_front();
            check($sformatf("addr%0d_due", e.id), e.due, cyc);
            check($sformatf("addr%0d", e.id), 32'(bus.read_address), 32'(e.a));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            px_t e;
            e = pq.pop_front();
            check($sformatf("px%0d_due", e.id), e.due, cyc);
            check($sformatf("px%0d_valid", e.id), 32'(bus.pixel_valid), 32'(e.v));
            check($sformatf("px%0d_rgb", e.id), {8'd0, bus.Red, bus.Green, bus.Blue}, {8'd0, e.rgb});
        end
    end

    // Drive one scan position; use_lit substitutes a hand-derived colour for the model's.
    task automatic drive(input int x, input int y, input bit use_lit, input logic [23:0] lit);
        px_t p;
        ad_t a;
        bit inb;
        int adr;
        logic [4:0] idx;
        inb = (x >= 245) && (x < 395) && (y >= 180) && (y < 300);
        adr = inb ? (y - 180) * 150 + (x - 245) : 0;
        idx = rom_fn(15'(adr));
        p.id  = next_id;
        a.id  = next_id;
        next_id++;
        p.v   = inb && (idx != 5'd0) && (m_state != 0);
        p.rgb = !p.v ? 24'h0 : (use_lit ? lit : scale_rgb(PALETTE[idx], m_lvl));
        a.a   = 15'(adr);
        DrawX = 10'(x);
        DrawY = 10'(y);
        a.due = cyc + 1;
        p.due = cyc + 3;
        aq.push_back(a);
        pq.push_back(p);
        @(negedge clk);
    endtask

    task automatic drive_px(input int x, input int y);
        drive(x, y, 1'b0, 24'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (pq.size() == 0 && aq.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(pq.size() + aq.size()), 32'd0);
    endtask

    task automatic ctl(input logic trig, input logic clr);
        win_trigger = trig;
        win_clear   = clr;
        @(negedge clk);
        win_trigger = 1'b0;
        win_clear   = 1'b0;
        if (clr) m_state = 0;
        else if (trig && m_state == 0) begin
            m_state = 1;
            m_lvl   = 0;
            m_fcnt  = 0;
        end
        check("overlay_active", 32'(overlay_active), 32'(m_state != 0));
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (m_state == 1) begin
            m_fcnt++;
            if (m_fcnt == 4) begin
                m_fcnt = 0;
                m_lvl++;
                if (m_lvl == 7) m_state = 2;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_overlay"}, 32'(overlay_active), 32'd0);
        check({tag, "_valid"}, 32'(bus.pixel_valid), 32'd0);
        check({tag, "_rgb"}, {8'd0, bus.Red, bus.Green, bus.Blue}, 32'd0);
        check({tag, "_addr"}, 32'(bus.read_address), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        frame_start = 1'b0;
        win_trigger = 1'b0;
        win_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(negedge clk);

        drive_px(245, 180);
        drain();

        ctl(1'b1, 1'b0);
        drive_px(245, 180);
        drive_px(394, 299);
        drive_px(395, 299);
        drive_px(244, 180);
        drive_px(245, 179);
        drive_px(394, 300);
        drive_px(274, 180);
        drive(247, 180, 1'b1, 24'h1F1008);
        drain();

        for (int lv = 0; lv < 7; lv++) begin
            repeat (4) pulse_frame();
            if (lv == 1) ctl(1'b1, 1'b0);
            drive_px(247, 180);
            drive_px(274, 180);
            drive_px(245, 180);
            drain();
        end
        check("show_state", 32'(m_state), 32'd2);
        drive(247, 180, 1'b1, 24'hFF8040);
        drain();
        repeat (4) pulse_frame();
        drive(247, 180, 1'b1, 24'hFF8040);
        drain();

        ctl(1'b0, 1'b1);
        drive_px(247, 180);
        drain();

        ctl(1'b1, 1'b0);
        repeat (2) pulse_frame();
        ctl(1'b1, 1'b1);
        drive_px(247, 180);
        drain();

        ctl(1'b1, 1'b0);
        repeat (16) pulse_frame();
        drive(247, 180, 1'b1, 24'h9F5028);
        drain();

        Reset_n = 1'b0;
        @(negedge clk);
        m_state = 0;
        m_lvl   = 0;
        m_fcnt  = 0;
        check_reset_outputs("midfade_reset");
        Reset_n = 1'b1;
        @(negedge clk);
        drive_px(247, 180);
        drain();
        ctl(1'b1, 1'b0);
        drive(247, 180, 1'b1, 24'h1F1008);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
